// File: rtl/minisrc_pkg.sv
// minisrc_pkg: op and FSM state encodings shared by the Mini SRC mul/div unit and ALU decode
package minisrc_pkg;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/cond_negate.sv
// cond_negate: combinational two's-complement negate when neg is set
module cond_negate #(
  parameter int N = 32
) (
  input  logic [N-1:0] in,
  input  logic         neg,
  output logic [N-1:0] out
);
  always_comb out = neg ? -in : in;
endmodule

// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit: WIDTH-generic multi-cycle shift/add multiply and restoring divide, HI:LO results
module seq_muldiv_unit
  import minisrc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_t state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [2*WIDTH-1:0] acc, fix_in, fix_out;
  logic [WIDTH-1:0] opnd, mag_a, mag_b, rem_out, mul_add, hi, lo;
  logic [WIDTH:0] sum, shifted, diff;
  logic op_r, dz, neg_q, neg_r, accept, dz_req;
  assign accept = start && (state == IDLE || state == DONE);
  assign dz_req = op == OP_DIV && b == '0;
  cond_negate #(.N(WIDTH)) u_mag_a (.in(a), .neg(is_signed & a[WIDTH-1]), .out(mag_a));
  cond_negate #(.N(WIDTH)) u_mag_b (.in(b), .neg(is_signed & b[WIDTH-1]), .out(mag_b));
  cond_negate #(.N(2*WIDTH)) u_fix (.in(fix_in), .neg(neg_q), .out(fix_out));
  cond_negate #(.N(WIDTH)) u_rem (.in(acc[2*WIDTH-1:WIDTH]), .neg(neg_r), .out(rem_out));
  always_ff @(posedge clk or posedge clr)
    if (clr) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: state_nxt = accept ? (dz_req ? FIX : CALC) : IDLE;
      CALC:       state_nxt = (count == CNT_W'(1)) ? FIX : CALC;
      FIX:        state_nxt = DONE;
    endcase
  end
  always_comb begin
    busy = state == CALC || state == FIX;
    done = state == DONE;
  end
  // acc holds {partial, multiplier} for mul, {remainder, dividend/quotient} for div
  always_comb begin
    mul_add = acc[0] ? opnd : '0;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = shifted - {1'b0, opnd};
    fix_in = op_r ? {{WIDTH{1'b0}}, acc[WIDTH-1:0]} : acc;
    hi = dz ? acc[2*WIDTH-1:WIDTH] : op_r ? rem_out : fix_out[2*WIDTH-1:WIDTH];
    lo = dz ? '1 : fix_out[WIDTH-1:0];
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      count <= '0;
      acc <= '0;
      opnd <= '0;
      op_r <= 1'b0;
      dz <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      op_r <= op;
      dz <= dz_req;
      neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= is_signed & a[WIDTH-1];
      count <= CNT_W'(WIDTH);
      opnd <= op == OP_DIV ? mag_b : mag_a;
      acc <= dz_req ? {a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, op == OP_DIV ? mag_a : mag_b};
    end else if (state == CALC) begin
      count <= count - CNT_W'(1);
      acc <= op_r ? {diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]}
                  : {sum, acc[WIDTH-1:1]};
    end else if (state == FIX) begin
      result_hi <= hi;
      result_lo <= lo;
      div_by_zero <= dz;
    end
endmodule
